e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit, beside the ALU and directly upstream of the EX/MEM pipeline register.
- Executes mult, multu, div, divu, mthi and mtlo with multi-cycle latency, and holds the architectural HI/LO registers.
- Drives the mfhi/mflo read value that the E stage muxes into the ALU result fed to M.
- Exports busy so the hazard unit can stall MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- E_A  input  32  rs operand (forwarded)
- E_B  input  32  rt operand (forwarded)
- E_mdu_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as NONE
- E_mdu_en  input  1  E instruction valid (not bubble/flushed); qualifies all state changes
- E_mdu_start  output  1  combinational: E_mdu_en & op∈{1..4} & !E_mdu_busy
- E_mdu_busy  output  1  operation in flight
- E_HI  output  32  current HI register
- E_LO  output  32  current LO register
- E_mdu_out  output  32  combinational: HI if op=MFHI, LO if op=MFLO, else 0

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, state IDLE, pending results=0. All outputs derive from these values.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Start:
  - In IDLE, E_mdu_start=1 at rising edge → operands captured and 64-bit result computed into pending {hi,lo}.
  - Counter loads MULT_CYCLES or DIV_CYCLES; state → RUN.
- RUN:
  - counter decrements each edge.
  - On the edge where counter reaches 0: HI/LO ← pending, busy→0, state → IDLE.
  - busy is high exactly N cycles after the start edge. HI/LO hold new values in the first cycle busy=0.
- Arithmetic:
  - MULT: signed 32×32→64; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: unsigned 32×32→64; same HI/LO split.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divisor 0 (DIV or DIVU): unit goes busy for DIV_CYCLES as normal; on completion HI/LO are left unchanged.
- MTHI/MTLO:
  - In IDLE with E_mdu_en=1, HI (resp. LO) ← E_A at the next edge, no busy.
  - While busy, MTHI/MTLO and mult/div ops are ignored; the hazard unit guarantees they never arrive then, and the bench checks that they have no effect.
- MFHI/MFLO:
  - E_mdu_out reflects the register value; no state change.
  - While busy, E_mdu_out still shows the old HI/LO; stalling is the hazard unit's job.
- E_mdu_en=0: no state change regardless of op. An in-flight operation continues.
- Reset asserted mid-operation: abort immediately. HI/LO=0, busy=0; pending result discarded.
- E_mdu_start and E_mdu_busy are never both 1.

Test Plan:
- Reset → release; MULT A=0xFFFFFFFE(-2), B=3 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001; MFHI in the next cycle gives E_mdu_out=0xFFFFFFFE.
- DIV A=0xFFFFFFF9(-7), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO → busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- Start MULT; during busy issue MTLO 0x55 and DIV (en=1) → both ignored, E_mdu_start=0; final HI/LO equal the MULT result.
- Start DIV; drop reset low at busy cycle 4 → busy=0, HI=LO=0 immediately (no clock); after release, MTHI 0x1234 → HI=0x1234 next edge.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// multi-cycle busy window, and serves mfhi/mflo reads to the E-stage result mux.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic [3:0]  E_mdu_op,
    input  logic        E_mdu_en,
    output logic        E_mdu_start,
    output logic        E_mdu_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_mdu_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic          pwe_q, pwe_d;

    logic        is_mul, is_div, is_signed;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] a_mag, b_mag, div_a, div_b, uq, ur, quo, rem;

    // Op decode; codes 9..15 fall through as NONE.
    always_comb begin
        is_mul    = (E_mdu_op == OP_MULT) || (E_mdu_op == OP_MULTU);
        is_div    = (E_mdu_op == OP_DIV)  || (E_mdu_op == OP_DIVU);
        is_signed = (E_mdu_op == OP_MULT) || (E_mdu_op == OP_DIV);
    end

    assign E_mdu_busy  = (state_q == RUN);
    assign E_mdu_start = E_mdu_en && (is_mul || is_div) && !E_mdu_busy;
    assign E_HI        = hi_q;
    assign E_LO        = lo_q;
    assign E_mdu_out   = (E_mdu_op == OP_MFHI) ? hi_q :
                         (E_mdu_op == OP_MFLO) ? lo_q : 32'd0;

    // Multiply: extend to 64 bits, the low 64 bits of the product are exact.
    always_comb begin
        mul_a = is_signed ? {{32{E_A[31]}}, E_A} : {32'd0, E_A};
        mul_b = is_signed ? {{32{E_B[31]}}, E_B} : {32'd0, E_B};
        prod  = mul_a * mul_b;
    end

    // Divide on magnitudes, then restore signs. Keeps 0x80000000 / -1 well
    // defined (|q| = 0x80000000, positive) and avoids any divide by zero.
    always_comb begin
        a_mag = E_A[31] ? (32'd0 - E_A) : E_A;
        b_mag = E_B[31] ? (32'd0 - E_B) : E_B;
        div_a = is_signed ? a_mag : E_A;
        div_b = is_signed ? b_mag : E_B;
        if (div_b == 32'd0) div_b = 32'd1;
        uq    = div_a / div_b;
        ur    = div_a % div_b;
        quo   = (is_signed && (E_A[31] ^ E_B[31])) ? (32'd0 - uq) : uq;
        rem   = (is_signed && E_A[31]) ? (32'd0 - ur) : ur;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwe_d   = pwe_q;
        case (state_q)
            IDLE: begin
                if (E_mdu_start) begin
                    {phi_d, plo_d} = is_mul ? prod : {rem, quo};
                    pwe_d          = is_mul || (E_B != 32'd0);
                    cnt_d          = is_mul ? MULT_LD : DIV_LD;
                    state_d        = RUN;
                end else if (E_mdu_en && E_mdu_op == OP_MTHI) begin
                    hi_d = E_A;
                end else if (E_mdu_en && E_mdu_op == OP_MTLO) begin
                    lo_d = E_A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    // A zero divisor completes silently, leaving HI/LO intact.
                    if (pwe_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwe_q   <= pwe_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed + random checks of e_mdu against an arithmetic model of HI/LO.
module tb_e_mdu;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  op = '0;
    logic        en = 1'b0;
    logic        start, busy;
    logic [31:0] hi, lo, out;

    int total = 0;
    int bad   = 0;
    logic [31:0] mhi = '0, mlo = '0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_A(A), .E_B(B), .E_mdu_op(op),
        .E_mdu_en(en), .E_mdu_start(start), .E_mdu_busy(busy),
        .E_HI(hi), .E_LO(lo), .E_mdu_out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div; optionally interfere during busy or abort via reset.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit interfere, input int abort_at);
        int n;
        bit upd;
        longint sa, sb, sq, sr;
        logic [63:0] p;
        logic [31:0] ehi, elo;
        n   = (o == OP_MULT || o == OP_MULTU) ? 5 : 10;
        upd = 1'b1;
        ehi = mhi;
        elo = mlo;
        case (o)
            OP_MULT: begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                p = 64'(sa * sb); ehi = p[63:32]; elo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b}; ehi = p[63:32]; elo = p[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) upd = 1'b0;
                else begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                    sq = sa / sb; sr = sa % sb;
                    p = 64'(sq); elo = p[31:0];
                    p = 64'(sr); ehi = p[31:0];
                end
            end
            default: begin
                if (b == 32'd0) upd = 1'b0;
                else begin elo = a / b; ehi = a % b; end
            end
        endcase
        @(negedge clk);
        en = 1'b1; op = o; A = a; B = b;
        #1 chk("start_pulse", start, 1);
        chk("idle_before", busy, 0);
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin en = 1'b0; op = OP_NONE; end
            if (interfere && i == 1) begin en = 1'b1; op = OP_MTLO; A = 32'h55; end
            if (interfere && i == 2) begin en = 1'b1; op = OP_DIV; A = 32'd9; B = 32'd2; end
            if (interfere && i == 3) begin en = 1'b0; op = OP_NONE; end
            #1;
            if (abort_at == i) begin
                reset = 1'b0;
                #1 chk("abort_busy", busy, 0);
                chk("abort_hi", hi, 0);
                chk("abort_lo", lo, 0);
                mhi = '0; mlo = '0;
                @(negedge clk) reset = 1'b1;
                return;
            end
            chk("busy_run", busy, 1);
            chk("no_start_busy", start, 0);
            chk("hold_hi", hi, mhi);
            chk("hold_lo", lo, mlo);
        end
        @(negedge clk);
        #1 chk("busy_done", busy, 0);
        if (upd) begin mhi = ehi; mlo = elo; end
        chk("res_hi", hi, mhi);
        chk("res_lo", lo, mlo);
    endtask

    task automatic do_mt(input logic [3:0] o, input logic [31:0] v);
        @(negedge clk);
        en = 1'b1; op = o; A = v;
        #1 chk("mt_no_start", start, 0);
        @(posedge clk);
        #1;
        if (o == OP_MTHI) mhi = v; else mlo = v;
        en = 1'b0; op = OP_NONE;
        chk("mt_hi", hi, mhi);
        chk("mt_lo", lo, mlo);
        chk("mt_busy", busy, 0);
    endtask

    task automatic mf_check();
        @(negedge clk);
        en = 1'b1; op = OP_MFHI;
        #1 chk("mfhi", out, mhi);
        op = OP_MFLO;
        #1 chk("mflo", out, mlo);
        op = OP_NONE;
        #1 chk("out_none", out, 0);
        op = 4'd12;
        #1 chk("out_op12", out, 0);
        chk("op12_no_start", start, 0);
        en = 1'b0; op = OP_NONE;
    endtask

    logic [31:0] spec_v [4];
    logic [31:0] ra, rb;
    int          k;

    initial begin
        spec_v[0] = 32'h0; spec_v[1] = 32'h1; spec_v[2] = 32'h8000_0000; spec_v[3] = 32'hFFFF_FFFF;

        #2 chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_start", start, 0);
        @(negedge clk) reset = 1'b1;

        do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
        chk("mult_hi_k", hi, 32'hFFFF_FFFF);
        chk("mult_lo_k", lo, 32'hFFFF_FFFA);

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        chk("multu_hi_k", hi, 32'hFFFF_FFFE);
        @(negedge clk); en = 1'b1; op = OP_MFHI;
        #1 chk("mfhi_k", out, 32'hFFFF_FFFE);
        en = 1'b0; op = OP_NONE;

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        chk("div_lo_k", lo, 32'hFFFF_FFFD);
        chk("div_hi_k", hi, 32'hFFFF_FFFF);

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        chk("ovf_lo_k", lo, 32'h8000_0000);
        chk("ovf_hi_k", hi, 32'h0);

        do_mt(OP_MTHI, 32'h11);
        do_mt(OP_MTLO, 32'h22);
        do_op(OP_DIVU, 32'd100, 32'd0, 1'b0, -1);
        chk("divz_hi_k", hi, 32'h11);
        chk("divz_lo_k", lo, 32'h22);

        do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, -1);
        chk("intf_lo_k", lo, 32'hFFFF_FFEB);

        // Disabled instruction must not start or write anything.
        @(negedge clk); en = 1'b0; op = OP_MULT; A = 32'd5; B = 32'd5;
        #1 chk("en0_start", start, 0);
        @(negedge clk); op = OP_MTHI;
        @(negedge clk);
        chk("en0_busy", busy, 0);
        chk("en0_hi", hi, mhi);
        op = OP_NONE;

        do_op(OP_DIV, 32'd1000, 32'd7, 1'b0, 3);
        do_mt(OP_MTHI, 32'h1234);
        chk("post_abort_hi_k", hi, 32'h1234);
        mf_check();

        for (int it = 0; it < 30; it++) begin
            ra = ($urandom_range(0, 3) == 0) ? spec_v[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? spec_v[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
            k = $urandom_range(1, 6);
            if (k == 5) do_mt(OP_MTHI, ra);
            else if (k == 6) do_mt(OP_MTLO, ra);
            else do_op(4'(k), ra, rb, ($urandom_range(0, 3) == 0), -1);
            mf_check();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
